// File: rtl/threshold_alarm_monitor_pkg.sv
// Shared types and constants for the threshold alarm monitor slice.
package threshold_alarm_monitor_pkg;

  // Sample width used by the monitor and its comparators
  localparam int SAMPLE_W = 4;

  // Width of the consecutive-qualifier (debounce) counter
  localparam int DEB_W = 4;

  // Legal range for the DEBOUNCE parameter
  localparam int DEB_MIN = 1;
  localparam int DEB_MAX = 15;

  // Alarm FSM: LOW/ARMING are alarm-off, HIGH/DISARMING are alarm-on
  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_ARMING    = 2'd1,
    ST_HIGH      = 2'd2,
    ST_DISARMING = 2'd3
  } alarm_state_t;

  // True for states in which the alarm level is asserted
  function automatic logic is_alarm_state(input alarm_state_t st);
    return (st == ST_HIGH) || (st == ST_DISARMING);
  endfunction

endpackage

// File: rtl/threshold_alarm_monitor_magnitude_comparator.sv
// Unsigned magnitude comparator; GREATER selects a>b, otherwise a<b.
module magnitude_comparator
  import threshold_alarm_monitor_pkg::*;
#(
  parameter int W       = SAMPLE_W,
  parameter bit GREATER = 1'b1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         result
);

  // Strict comparison: equality never produces a hit
  always_comb begin
    if (GREATER) begin
      result = (a > b);
    end else begin
      result = (a < b);
    end
  end

endmodule

// File: rtl/threshold_alarm_monitor.sv
// Debounced, hysteretic threshold alarm with event counter and peak tracker.
module threshold_alarm_monitor
  import threshold_alarm_monitor_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] thr_hi,
  input  logic [SAMPLE_W-1:0] thr_lo,
  input  logic                clear,
  output logic                alarm,
  output logic                alarm_rise,
  output logic                alarm_fall,
  output logic [CNT_W-1:0]    event_cnt,
  output logic [SAMPLE_W-1:0] peak,
  output logic                peak_valid
);

  if ((DEBOUNCE < DEB_MIN) || (DEBOUNCE > DEB_MAX)) begin : g_bad_debounce
    $fatal(1, "threshold_alarm_monitor: DEBOUNCE=%0d outside %0d..%0d",
           DEBOUNCE, DEB_MIN, DEB_MAX);
  end

  localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic                s1_v;
  logic [SAMPLE_W-1:0] s1_d;
  logic                above;
  logic                below;
  logic                above_peak;
  alarm_state_t        state;
  alarm_state_t        state_nxt;
  logic [DEB_W-1:0]    deb;
  logic [DEB_W-1:0]    deb_nxt;
  logic [DEB_W-1:0]    deb_inc;
  logic                rise_nxt;
  logic                fall_nxt;

  // Stage 1: register the incoming sample and its qualifier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_d <= '0;
    end else if (clear) begin
      s1_v <= 1'b0;
      s1_d <= '0;
    end else begin
      s1_v <= sample_valid;
      s1_d <= sample;
    end
  end

  magnitude_comparator #(.W(SAMPLE_W), .GREATER(1'b1)) u_cmp_hi (
    .a      (s1_d),
    .b      (thr_hi),
    .result (above)
  );

  magnitude_comparator #(.W(SAMPLE_W), .GREATER(1'b0)) u_cmp_lo (
    .a      (s1_d),
    .b      (thr_lo),
    .result (below)
  );

  magnitude_comparator #(.W(SAMPLE_W), .GREATER(1'b1)) u_cmp_peak (
    .a      (s1_d),
    .b      (peak),
    .result (above_peak)
  );

  assign deb_inc = deb + 4'd1;
  assign alarm   = is_alarm_state(state);

  // Next-state logic: off states watch only 'above', on states watch only 'below'
  always_comb begin
    state_nxt = state;
    deb_nxt   = deb;
    if (s1_v) begin
      unique case (state)
        ST_LOW: begin
          if (above) begin
            if (DEBOUNCE == 1) begin
              state_nxt = ST_HIGH;
              deb_nxt   = '0;
            end else begin
              state_nxt = ST_ARMING;
              deb_nxt   = 4'd1;
            end
          end
        end
        ST_ARMING: begin
          if (above) begin
            if (deb_inc == DEB_TARGET) begin
              state_nxt = ST_HIGH;
              deb_nxt   = '0;
            end else begin
              deb_nxt = deb_inc;
            end
          end else begin
            state_nxt = ST_LOW;
            deb_nxt   = '0;
          end
        end
        ST_HIGH: begin
          if (below) begin
            if (DEBOUNCE == 1) begin
              state_nxt = ST_LOW;
              deb_nxt   = '0;
            end else begin
              state_nxt = ST_DISARMING;
              deb_nxt   = 4'd1;
            end
          end
        end
        ST_DISARMING: begin
          if (below) begin
            if (deb_inc == DEB_TARGET) begin
              state_nxt = ST_LOW;
              deb_nxt   = '0;
            end else begin
              deb_nxt = deb_inc;
            end
          end else begin
            state_nxt = ST_HIGH;
            deb_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ST_LOW;
          deb_nxt   = '0;
        end
      endcase
    end
    rise_nxt = (state_nxt == ST_HIGH) && !is_alarm_state(state);
    fall_nxt = (state_nxt == ST_LOW)  &&  is_alarm_state(state);
  end

  // FSM state, debounce count and edge pulses; clear suppresses any pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOW;
      deb        <= '0;
      alarm_rise <= 1'b0;
      alarm_fall <= 1'b0;
    end else if (clear) begin
      state      <= ST_LOW;
      deb        <= '0;
      alarm_rise <= 1'b0;
      alarm_fall <= 1'b0;
    end else begin
      state      <= state_nxt;
      deb        <= deb_nxt;
      alarm_rise <= rise_nxt;
      alarm_fall <= fall_nxt;
    end
  end

  // Saturating alarm-entry counter and running peak of valid samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_cnt  <= '0;
      peak       <= '0;
      peak_valid <= 1'b0;
    end else if (clear) begin
      event_cnt  <= '0;
      peak       <= '0;
      peak_valid <= 1'b0;
    end else begin
      if (rise_nxt && (event_cnt != '1)) begin
        event_cnt <= event_cnt + CNT_ONE;
      end
      if (s1_v && (!peak_valid || above_peak)) begin
        peak       <= s1_d;
        peak_valid <= 1'b1;
      end
    end
  end

endmodule
